// File: rtl/reg_dst_stage_if.sv
// Bundle of the destination-register stage signals: decode-side inputs, hazard sources and
// the registered destination outputs.
interface reg_dst_stage_if #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 8
);
    logic [NUM_IN*WIDTH-1:0] inp;
    logic [SEL_W-1:0]        select;
    logic                    in_valid;
    logic                    reg_write_in;
    logic                    stall;
    logic                    flush;
    logic [WIDTH-1:0]        src_a;
    logic [WIDTH-1:0]        src_b;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic                    reg_write_out;
    logic                    match_a;
    logic                    match_b;
    logic [CNT_W-1:0]        wr_count;

    modport master (
        output inp, select, in_valid, reg_write_in, stall, flush, src_a, src_b,
        input  out, out_valid, reg_write_out, match_a, match_b, wr_count
    );

    modport slave (
        input  inp, select, in_valid, reg_write_in, stall, flush, src_a, src_b,
        output out, out_valid, reg_write_out, match_a, match_b, wr_count
    );
endinterface

// File: rtl/reg_dst_stage.sv
// Destination-register pipeline stage: picks rt/rd/link, registers it with a commit flag,
// flags RAW hazards against younger sources and counts committed register writes.
module reg_dst_stage #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input logic            clk,
    input logic            reset,
    reg_dst_stage_if.slave bus
);

    logic [WIDTH-1:0] cand;
    logic             sel_ok;
    logic             load_wr;

    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             wr_q;
    logic [CNT_W-1:0] cnt_q;

    // Out-of-range selects resolve to a zero, non-writing destination.
    always_comb begin
        cand   = '0;
        sel_ok = 1'b0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (int'(bus.select) == k) begin
                cand   = bus.inp[k*WIDTH +: WIDTH];
                sel_ok = 1'b1;
            end
        end
    end

    assign load_wr = bus.in_valid & bus.reg_write_in & sel_ok & (cand != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
        end else if (!bus.stall) begin
            out_q   <= cand;
            valid_q <= bus.in_valid;
            wr_q    <= load_wr;
            if (load_wr && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.out           = out_q;
    assign bus.out_valid     = valid_q;
    assign bus.reg_write_out = wr_q;
    assign bus.wr_count      = cnt_q;

    // Register 0 never hazards; wr_q already implies out_q != 0, the explicit check is cheap.
    assign bus.match_a = valid_q & wr_q & (bus.src_a == out_q) & (bus.src_a != '0);
    assign bus.match_b = valid_q & wr_q & (bus.src_b == out_q) & (bus.src_b != '0);

endmodule

// File: tb/tb_reg_dst_stage.sv
// Directed and randomized checks of reg_dst_stage against a behavioural model, using a
// default-width instance and a 2-bit-counter instance driven in lockstep.
module tb_reg_dst_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] inp;
    logic [1:0]  select;
    logic        in_valid, reg_write_in, stall, flush;
    logic [4:0]  src_a, src_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int unsigned m_out, m_valid, m_wr, m_cnt8, m_cnt2;

    int unsigned sweep_out[4] = '{7, 12, 31, 0};
    int unsigned sweep_wr[4]  = '{1, 1, 1, 0};
    int unsigned sat_cnt[5]   = '{1, 2, 3, 3, 3};

    reg_dst_stage_if #(.CNT_W(8)) bus8 ();
    reg_dst_stage_if #(.CNT_W(2)) bus2 ();

    assign bus8.inp = inp;           assign bus2.inp = inp;
    assign bus8.select = select;     assign bus2.select = select;
    assign bus8.in_valid = in_valid; assign bus2.in_valid = in_valid;
    assign bus8.reg_write_in = reg_write_in;
    assign bus2.reg_write_in = reg_write_in;
    assign bus8.stall = stall;       assign bus2.stall = stall;
    assign bus8.flush = flush;       assign bus2.flush = flush;
    assign bus8.src_a = src_a;       assign bus2.src_a = src_a;
    assign bus8.src_b = src_b;       assign bus2.src_b = src_b;

    reg_dst_stage #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus8));
    reg_dst_stage #(.CNT_W(2)) dut_s (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what one clock edge does to the stage, from the stated rules.
    function automatic void model_edge();
        int unsigned c;
        int unsigned all_cands;
        if (reset) begin
            m_out = 0; m_valid = 0; m_wr = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (flush) begin
            m_out = 0; m_valid = 0; m_wr = 0;
        end else if (!stall) begin
            all_cands = inp;
            c = (select < 3) ? ((all_cands >> (select * 5)) % 32) : 0;
            m_out   = c;
            m_valid = in_valid;
            m_wr    = (in_valid && reg_write_in && select < 3 && c != 0) ? 1 : 0;
            if (m_wr == 1) begin
                m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
                m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
            end
        end
    endfunction

    function automatic int unsigned model_match(input int unsigned src);
        return (m_valid == 1 && m_wr == 1 && src == m_out && src != 0) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " out"}, 32'(bus8.out), m_out);
        chk({tag, " out_valid"}, 32'(bus8.out_valid), m_valid);
        chk({tag, " reg_write_out"}, 32'(bus8.reg_write_out), m_wr);
        chk({tag, " wr_count"}, 32'(bus8.wr_count), m_cnt8);
        chk({tag, " wr_count_sat"}, 32'(bus2.wr_count), m_cnt2);
        chk({tag, " match_a"}, 32'(bus8.match_a), model_match(src_a));
        chk({tag, " match_b"}, 32'(bus8.match_b), model_match(src_b));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic [4:0] c2, input logic [4:0] c1, input logic [4:0] c0,
                          input logic [1:0] sel, input logic v, input logic rw);
        inp = {c2, c1, c0};
        select = sel;
        in_valid = v;
        reg_write_in = rw;
    endtask

    initial begin
        m_out = 0; m_valid = 0; m_wr = 0; m_cnt8 = 0; m_cnt2 = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        src_a = 5'd0; src_b = 5'd5;
        set_in(5'd31, 5'd12, 5'd7, 2'd0, 1'b1, 1'b1);

        cycle("reset");
        chk("reset out", 32'(bus8.out), 0);
        chk("reset valid", 32'(bus8.out_valid), 0);
        chk("reset match_b", 32'(bus8.match_b), 0);

        // Saturation on the 2-bit counter instance.
        reset = 1'b0;
        set_in(5'd31, 5'd12, 5'd7, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle("sat");
            chk("sat count", 32'(bus2.wr_count), sat_cnt[i]);
        end

        reset = 1'b1;
        cycle("reset2");
        reset = 1'b0;

        // Select sweep including an out-of-range select.
        for (int i = 0; i < 4; i++) begin
            set_in(5'd31, 5'd12, 5'd7, 2'(i), 1'b1, 1'b1);
            cycle("sweep");
            chk("sweep out", 32'(bus8.out), sweep_out[i]);
            chk("sweep wr", 32'(bus8.reg_write_out), sweep_wr[i]);
        end
        chk("sweep count", 32'(bus8.wr_count), 3);

        set_in(5'd31, 5'd12, 5'd0, 2'd0, 1'b1, 1'b1);
        cycle("zero");
        chk("zero out", 32'(bus8.out), 0);
        chk("zero valid", 32'(bus8.out_valid), 1);
        chk("zero wr", 32'(bus8.reg_write_out), 0);
        chk("zero count", 32'(bus8.wr_count), 3);

        // Stall holds, flush wins over stall.
        set_in(5'd31, 5'd12, 5'd7, 2'd1, 1'b1, 1'b1);
        cycle("load12");
        stall = 1'b1;
        set_in(5'd31, 5'd12, 5'd7, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall out", 32'(bus8.out), 12);
            chk("stall count", 32'(bus8.wr_count), 4);
        end
        flush = 1'b1;
        cycle("flush");
        chk("flush out", 32'(bus8.out), 0);
        chk("flush valid", 32'(bus8.out_valid), 0);
        chk("flush count", 32'(bus8.wr_count), 4);
        stall = 1'b0; flush = 1'b0;

        // Hazard compare.
        set_in(5'd31, 5'd12, 5'd7, 2'd1, 1'b1, 1'b1);
        cycle("haz load");
        src_a = 5'd12; src_b = 5'd7;
        #1;
        chk("haz match_a", 32'(bus8.match_a), 1);
        chk("haz match_b", 32'(bus8.match_b), 0);
        set_in(5'd31, 5'd12, 5'd7, 2'd1, 1'b1, 1'b0);
        cycle("haz nowr");
        chk("haz nowr match_a", 32'(bus8.match_a), 0);
        set_in(5'd31, 5'd12, 5'd0, 2'd0, 1'b1, 1'b1);
        src_a = 5'd0; src_b = 5'd0;
        cycle("haz zero");
        chk("haz zero match_a", 32'(bus8.match_a), 0);
        chk("haz zero match_b", 32'(bus8.match_b), 0);

        // Reset mid-operation overrides flush and stall.
        reset = 1'b1;
        cycle("reset3");
        reset = 1'b0;
        set_in(5'd31, 5'd12, 5'd7, 2'd0, 1'b1, 1'b1);
        cycle("mid a");
        set_in(5'd31, 5'd12, 5'd7, 2'd2, 1'b1, 1'b1);
        cycle("mid b");
        chk("mid out", 32'(bus8.out), 31);
        chk("mid count", 32'(bus8.wr_count), 2);
        reset = 1'b1; flush = 1'b1; stall = 1'b1;
        src_a = 5'd31;
        cycle("mid reset");
        chk("mid reset out", 32'(bus8.out), 0);
        chk("mid reset count", 32'(bus8.wr_count), 0);
        chk("mid reset match_a", 32'(bus8.match_a), 0);
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        set_in(5'd31, 5'd9, 5'd7, 2'd1, 1'b1, 1'b1);
        cycle("after reset");
        chk("after reset out", 32'(bus8.out), 9);
        chk("after reset count", 32'(bus8.wr_count), 1);

        // Randomized traffic; zero candidates and hazard sources are biased in.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] c[3];
            for (int k = 0; k < 3; k++) begin
                c[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            end
            set_in(c[2], c[1], c[0], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0));
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            src_a = ($urandom_range(0, 2) == 0) ? 5'(m_out) : 5'($urandom_range(0, 31));
            src_b = ($urandom_range(0, 2) == 0) ? 5'(m_out) : 5'($urandom_range(0, 31));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dst_stage.md
REG_DST_STAGE -- requirements
Module: reg_dst_stage

Parameters
REQ-001 WIDTH, default 5, bit width of each register-address candidate and of out.
REQ-002 NUM_IN, default 3, number of candidate inputs (0 = rt, 1 = rd, 2 = link register constant).
REQ-003 SEL_W, default 2, width of select; the block SHALL require 2**SEL_W >= NUM_IN.
REQ-004 CNT_W, default 8, width of the write-commit counter.

Interface
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 inp  input  NUM_IN*WIDTH  packed candidates; candidate k occupies bits [k*WIDTH +: WIDTH].
REQ-008 select  input  SEL_W  candidate index.
REQ-009 in_valid  input  1  an instruction is presented this cycle.
REQ-010 reg_write_in  input  1  the presented instruction writes a register.
REQ-011 stall  input  1  hold the stage contents.
REQ-012 flush  input  1  squash the stage contents.
REQ-013 src_a, src_b  input  WIDTH each  source addresses of the younger instruction, used for hazard compare.
REQ-014 out  output  WIDTH  registered destination address.
REQ-015 out_valid  output  1  the stage holds a live instruction.
REQ-016 reg_write_out  output  1  the registered instruction commits a register write.
REQ-017 match_a, match_b  output  1 each  combinational hazard flags.
REQ-018 wr_count  output  CNT_W  saturating count of accepted register writes.

Function
REQ-019 The stage SHALL have one-cycle latency: inputs sampled on edge N appear on out/out_valid/reg_write_out after edge N.
REQ-020 Update priority on each edge SHALL be reset > flush > stall > load.
REQ-021 On a load, out SHALL take candidate[select] when select < NUM_IN, and SHALL take 0 otherwise.
REQ-022 On a load, out_valid SHALL take in_valid.
REQ-023 On a load, reg_write_out SHALL be in_valid AND reg_write_in AND (select < NUM_IN) AND (the selected candidate != 0).
REQ-024 A zero destination SHALL never assert reg_write_out, because register 0 is hard-wired.
REQ-025 While stall=1 and flush=0, out, out_valid, reg_write_out and wr_count SHALL hold their values.
REQ-026 On flush=1, out SHALL be 0, out_valid SHALL be 0 and reg_write_out SHALL be 0; wr_count SHALL hold, and stall is ignored.
REQ-027 wr_count SHALL increment by 1 on each load edge where the next reg_write_out is 1.
REQ-028 wr_count SHALL saturate at 2**CNT_W-1 and SHALL never wrap.
REQ-029 match_a SHALL equal out_valid AND reg_write_out AND (src_a == out); match_b is defined the same way using src_b.
REQ-030 match_a and match_b SHALL be purely combinational from current state and src inputs, and SHALL be 0 when the compared source is 0.
REQ-031 There SHALL be no unknown outputs after the first reset edge, for any select value, including an out-of-range one.

Reset
REQ-032 On a rising clk edge with reset=1, out SHALL be 0, out_valid 0, reg_write_out 0 and wr_count 0, regardless of flush or stall.
REQ-033 Reset asserted mid-stream SHALL discard the held instruction; the first load after reset deasserts SHALL behave as REQ-021 to REQ-023.
REQ-034 match_a and match_b SHALL be 0 while in reset state.

Verification
REQ-035 Select sweep: inp={5'd31, 5'd12, 5'd7}, in_valid=1, reg_write_in=1, select=0,1,2,3 on consecutive cycles. Required one cycle later: out = 7, 12, 31, 0; reg_write_out = 1, 1, 1, 0; wr_count ends at 3.
REQ-036 Zero destination: select=0 with candidate0=0, reg_write_in=1. Required: out=0, out_valid=1, reg_write_out=0, wr_count unchanged.
REQ-037 Stall versus flush: load out=12, then stall=1 for 3 cycles (out stays 12, count stays), then stall=1 and flush=1 together. Required: out=0, out_valid=0, count unchanged.
REQ-038 Hazard: stage holds out=12 with reg_write_out=1; src_a=12, src_b=7. Required: match_a=1, match_b=0; with reg_write_out=0 both flags are 0; with src_a=0 and out=0 both flags are 0.
REQ-039 Saturation: CNT_W=2, apply 5 consecutive valid writes. Required: wr_count reads 1, 2, 3, 3, 3.
REQ-040 Reset mid-operation: out=31, wr_count=2, then reset=1 for one edge with flush=1 and stall=1. Required: all outputs 0; on the next valid load of rd=9, out=9 and wr_count=1.
